// File: rtl/v_inst_queue_if.sv
// Push/pop bundle between the scalar issue stage and the vector instruction queue.
// The master side is the scalar pipeline together with the vector core consumer.
// The slave side is the queue itself.
interface v_inst_queue_if #(
    parameter int DEPTH  = 4,
    parameter int INST_W = 32,
    parameter int XLEN   = 64
);
    localparam int COUNT_W = $clog2(DEPTH) + 1;

    // Scalar push side
    logic               push_valid;
    logic [INST_W-1:0]  push_inst;
    logic [XLEN-1:0]    push_rs1;
    logic               push_ready;
    logic               push_illegal;

    // Vector core pop side
    logic               pop_valid;
    logic [INST_W-1:0]  pop_inst;
    logic [XLEN-1:0]    pop_rs1;
    logic               pop_ready;

    // Control and status
    logic               flush;
    logic [COUNT_W-1:0] count;
    logic               empty;

    modport slave (
        input  push_valid, push_inst, push_rs1, pop_ready, flush,
        output push_ready, push_illegal, pop_valid, pop_inst, pop_rs1, count, empty
    );

    modport master (
        output push_valid, push_inst, push_rs1, pop_ready, flush,
        input  push_ready, push_illegal, pop_valid, pop_inst, pop_rs1, count, empty
    );
endinterface

// File: rtl/v_inst_queue.sv
// Vector instruction queue: an in-order circular buffer that decouples the scalar
// pipeline from the vector core. Each entry binds a vector instruction to the rs1
// value read at issue time, so the vector core never touches the scalar register
// file. Non-vector opcodes are rejected at the push port and reported one cycle
// later on push_illegal.
module v_inst_queue #(
    parameter int DEPTH  = 4,
    parameter int INST_W = 32,
    parameter int XLEN   = 64
) (
    input  logic          clk,
    input  logic          rst,
    v_inst_queue_if.slave vq
);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COUNT_W = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = INST_W + XLEN;
    localparam int NUM_OPC = 3;

    // Accepted major opcodes: STORE-FP, LOAD-FP, OP-V (index 2, 1, 0).
    localparam logic [NUM_OPC*7-1:0] VEC_OPCODES = {7'b0100111, 7'b0000111, 7'b1010111};

    // Entry storage (not reset; contents are only meaningful while counted)
    logic [ENTRY_W-1:0] mem [DEPTH];

    // State registers
    logic [PTR_W-1:0]   wptr_reg,  wptr_next;
    logic [PTR_W-1:0]   rptr_reg,  rptr_next;
    logic [COUNT_W-1:0] count_reg, count_next;
    logic               illegal_reg, illegal_next;

    // Handshake decode
    logic [NUM_OPC-1:0] opc_hit;
    logic               is_vec;
    logic               push_ready_c;
    logic               pop_valid_c;
    logic               push_fire;
    logic               pop_fire;
    logic               wr_en;
    logic [ENTRY_W-1:0] head_entry;

    // One comparator per accepted opcode; any hit marks the push as a vector op.
    generate
        for (genvar gi = 0; gi < NUM_OPC; gi++) begin : g_opc
            assign opc_hit[gi] = (vq.push_inst[6:0] == VEC_OPCODES[gi*7 +: 7]);
        end
    endgenerate

    assign is_vec = |opc_hit;

    // Handshake qualification, pointer and occupancy next-state (flush wins).
    always_comb begin
        push_ready_c = 1'b0;
        pop_valid_c  = 1'b0;
        push_fire    = 1'b0;
        pop_fire     = 1'b0;
        wr_en        = 1'b0;
        illegal_next = 1'b0;
        wptr_next    = wptr_reg;
        rptr_next    = rptr_reg;
        count_next   = count_reg;

        // A simultaneous pop frees the slot, so a full queue still accepts.
        push_ready_c = ~vq.flush & ((count_reg < COUNT_W'(DEPTH)) | vq.pop_ready);
        pop_valid_c  = ~vq.flush & (count_reg != '0);

        push_fire    = vq.push_valid & push_ready_c;
        pop_fire     = pop_valid_c & vq.pop_ready;
        wr_en        = push_fire & is_vec;
        illegal_next = push_fire & ~is_vec;

        if (wr_en) begin
            wptr_next = wptr_reg + PTR_W'(1);
        end
        if (pop_fire) begin
            rptr_next = rptr_reg + PTR_W'(1);
        end

        // Illegal pushes never change occupancy.
        if (wr_en && !pop_fire) begin
            count_next = count_reg + COUNT_W'(1);
        end else if (!wr_en && pop_fire) begin
            count_next = count_reg - COUNT_W'(1);
        end

        if (vq.flush) begin
            wptr_next    = '0;
            rptr_next    = '0;
            count_next   = '0;
            illegal_next = 1'b0;
        end
    end

    // Pointer, occupancy and illegal-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            count_reg   <= '0;
            illegal_reg <= 1'b0;
        end else begin
            wptr_reg    <= wptr_next;
            rptr_reg    <= rptr_next;
            count_reg   <= count_next;
            illegal_reg <= illegal_next;
        end
    end

    // Entry write; rs1 is captured here once and never re-read.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wptr_reg] <= {vq.push_inst, vq.push_rs1};
        end
    end

    // The head is read asynchronously so a pop needs no extra cycle of latency.
    assign head_entry = mem[rptr_reg];

    assign vq.pop_inst     = head_entry[ENTRY_W-1 -: INST_W];
    assign vq.pop_rs1      = head_entry[XLEN-1:0];
    assign vq.pop_valid    = pop_valid_c;
    assign vq.push_ready   = push_ready_c;
    assign vq.push_illegal = illegal_reg;
    assign vq.count        = count_reg;
    assign vq.empty        = (count_reg == '0);
endmodule

// File: tb/tb_v_inst_queue.sv
// Directed bench for v_inst_queue. The stimulus pushes each expected pop entry
// into a scoreboard queue as it issues a legal push; an independent monitor pops
// and compares whenever the DUT completes a pop handshake.
module tb_v_inst_queue;
    localparam int DEPTH  = 4;
    localparam int INST_W = 32;
    localparam int XLEN   = 64;

    localparam logic [31:0] OPV_INST   = 32'h0200_8057;
    localparam logic [31:0] LDFP_INST  = 32'h0000_6007;
    localparam logic [31:0] STFP_INST  = 32'h0000_6027;
    localparam logic [31:0] ADDI_INST  = 32'h0000_0013;

    logic clk;
    logic rst;

    v_inst_queue_if #(.DEPTH(DEPTH), .INST_W(INST_W), .XLEN(XLEN)) vq ();

    v_inst_queue #(.DEPTH(DEPTH), .INST_W(INST_W), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .vq  (vq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [INST_W+XLEN-1:0] expq [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Monitor: every completed pop is checked against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && vq.pop_valid === 1'b1 && vq.pop_ready === 1'b1) begin
            if (expq.size() == 0) begin
                n_checks++;
                $display("FAIL pop_unexpected: got inst=%h rs1=%h, required no pop", vq.pop_inst, vq.pop_rs1);
            end else begin
                logic [INST_W+XLEN-1:0] e;
                e = expq.pop_front();
                $display("pop  inst=%h rs1=%h (expected inst=%h rs1=%h)",
                         vq.pop_inst, vq.pop_rs1, e[INST_W+XLEN-1 -: INST_W], e[XLEN-1:0]);
                chk("pop_inst", 64'(vq.pop_inst), 64'(e[INST_W+XLEN-1 -: INST_W]));
                chk("pop_rs1", vq.pop_rs1, e[XLEN-1:0]);
            end
        end
    end

    // One bus cycle. exp_rdy is the hand-derived push_ready; legal says the
    // opcode is a vector one, so an accepted push must later pop out.
    task automatic cyc(input logic pv, input logic [31:0] inst, input logic [63:0] rs1,
                       input logic pr, input logic fl, input logic exp_rdy, input logic legal);
        vq.push_valid = pv;
        vq.push_inst  = inst;
        vq.push_rs1   = rs1;
        vq.pop_ready  = pr;
        vq.flush      = fl;
        @(negedge clk);
        if (pv) begin
            $display("push inst=%h rs1=%h pop_ready=%0b flush=%0b push_ready=%0b", inst, rs1, pr, fl, vq.push_ready);
            chk("push_ready", 64'(vq.push_ready), 64'(exp_rdy));
            if (exp_rdy && legal) expq.push_back({inst, rs1});
        end else begin
            $display("idle pop_ready=%0b flush=%0b", pr, fl);
        end
        if (fl) expq.delete();
        @(posedge clk);
        #1;
        vq.push_valid = 1'b0;
        vq.pop_ready  = 1'b0;
        vq.flush      = 1'b0;
    endtask

    // Idle cycle used to observe settled state at the negative edge.
    task automatic observe(input int exp_count, input logic exp_pv, input logic exp_ill);
        @(negedge clk);
        $display("state count=%0d pop_valid=%0b empty=%0b push_illegal=%0b",
                 vq.count, vq.pop_valid, vq.empty, vq.push_illegal);
        chk("count", 64'(vq.count), 64'(exp_count));
        chk("pop_valid", 64'(vq.pop_valid), 64'(exp_pv));
        chk("empty", 64'(vq.empty), 64'(exp_count == 0));
        chk("push_illegal", 64'(vq.push_illegal), 64'(exp_ill));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        vq.push_valid = 1'b0;
        vq.push_inst  = '0;
        vq.push_rs1   = '0;
        vq.pop_ready  = 1'b0;
        vq.flush      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_push_ready", 64'(vq.push_ready), 64'd1);
        @(posedge clk);
        #1;
        observe(0, 1'b0, 1'b0);

        // Single push then pop
        cyc(1'b1, OPV_INST, 64'h1234, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("head_inst", 64'(vq.pop_inst), 64'(OPV_INST));
        chk("head_rs1", vq.pop_rs1, 64'h1234);
        @(posedge clk);
        #1;
        observe(1, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        observe(0, 1'b0, 1'b0);

        // Fill to DEPTH, fifth push held off, drain in order
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, OPV_INST | (32'(i) << 15), 64'(i), 1'b0, 1'b0, 1'b1, 1'b1);
        observe(4, 1'b1, 1'b0);
        cyc(1'b1, STFP_INST, 64'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        observe(4, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        observe(0, 1'b0, 1'b0);

        // Full queue with simultaneous push and pop across pointer wrap
        for (int i = 0; i < 4; i++)
            cyc(1'b1, LDFP_INST | (32'(i) << 20), 64'h10 + 64'(i), 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            cyc(1'b1, STFP_INST | (32'(i) << 20), 64'h20 + 64'(i), 1'b1, 1'b0, 1'b1, 1'b1);
        observe(4, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        observe(0, 1'b0, 1'b0);

        // Illegal opcode rejected, then LOAD-FP accepted
        cyc(1'b1, ADDI_INST, 64'h99, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("illegal_pulse", 64'(vq.push_illegal), 64'd1);
        chk("illegal_count", 64'(vq.count), 64'd0);
        @(posedge clk);
        #1;
        observe(0, 1'b0, 1'b0);
        cyc(1'b1, LDFP_INST, 64'h77, 1'b0, 1'b0, 1'b1, 1'b1);
        observe(1, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Push into empty queue with pop_ready high: no bypass
        cyc(1'b1, OPV_INST, 64'h55, 1'b1, 1'b0, 1'b1, 1'b1);
        observe(1, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        observe(0, 1'b0, 1'b0);

        // Flush with push and pop requested in the same cycle
        for (int i = 0; i < 3; i++)
            cyc(1'b1, OPV_INST, 64'h30 + 64'(i), 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, OPV_INST, 64'h3f, 1'b1, 1'b1, 1'b0, 1'b1);
        observe(0, 1'b0, 1'b0);
        cyc(1'b1, STFP_INST, 64'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        observe(0, 1'b0, 1'b0);

        // Reset mid-operation discards queued entries
        cyc(1'b1, OPV_INST, 64'h41, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, LDFP_INST, 64'h42, 1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        expq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_push_ready", 64'(vq.push_ready), 64'd1);
        @(posedge clk);
        #1;
        observe(0, 1'b0, 1'b0);
        cyc(1'b1, LDFP_INST, 64'hBB, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        observe(0, 1'b0, 1'b0);

        chk("scoreboard_drained", 64'(expq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
